unidad_fetch: RTL and testbench
===============================

// Module: unidad_fetch
// PURPOSE
//  Instruction-fetch initiator for the 5-stage pipeline. Drives the 10-bit word address
//  into the synchronous instruction memory and tracks the 1-cycle read latency.
//  Presents {instruction, PC, valid} to the IF/ID register.
//  Honours HDU stalls, branch/jump redirects and HLT (all-zero word).
// PARAMETERS
//  ANCHO_DIR  10            address width (words); memory depth = 2**ANCHO_DIR
//  PC_RESET   10'd0         first address fetched after reset
//  HLT_CODE   32'h00000000  opcode that halts fetch
// PORTS
//  clk             in   1          clock; everything on posedge
//  reset_n         in   1          asynchronous, active-low reset
//  direccion       out  ANCHO_DIR  word address to instruction memory (combinational)
//  instruccion_mem in   32         registered memory data (rom[address sampled last edge])
//  stall           in   1          HDU stall: hold PC and the instruction presented
//  salto_valido    in   1          branch/jump taken this cycle
//  salto_destino   in   ANCHO_DIR  redirect target
//  instr_out       out  32         instruction to IF/ID (= instruccion_mem)
//  pc_out          out  ANCHO_DIR  address of instr_out (= pc_pend)
//  valida_out      out  1          instr_out is meaningful
//  detenido        out  1          1 while in HALT
// BEHAVIOUR
//  - Registers: pc (next address), pc_pend (address whose data is on instruccion_mem),
//    pend_valid, estado {ARRANQUE, FETCH, HALT}.
//  - Reset (async): pc = pc_pend = PC_RESET; pend_valid = 0; estado = ARRANQUE.
//    Output values: direccion = PC_RESET; valida_out = 0; detenido = 0; pc_out = PC_RESET.
//  - Address mux: direccion = salto_valido ? salto_destino
//    : (stall | estado==HALT) ? pc_pend : pc.
//    Re-reading pc_pend keeps instruccion_mem stable across a stall.
//  - Edge priority: salto_valido > stall > normal.
//      salto_valido: pc_pend <= destino, pc <= destino+1, pend_valid <= 1, estado <= FETCH.
//                    Leaves HALT, because an older branch may skip the HLT.
//      stall (FETCH): hold all registers. Stall is ignored in ARRANQUE.
//      ARRANQUE: pc_pend <= pc, pc <= pc+1, pend_valid <= 1, estado <= FETCH.
//      FETCH: same as ARRANQUE. If valida_out && instr_out==HLT_CODE, estado <= HALT
//             and pc/pc_pend are frozen instead.
//      HALT: hold. Leaves only on salto_valido or reset.
//  - valida_out = pend_valid && estado!=HALT; detenido = (estado==HALT).
//  - Latency: address out at edge k -> instruction valid after edge k; 0-bubble redirect.
//    IF/ID squash of the wrong-path word is the control unit's job.
//  - pc+1 wraps modulo 2**ANCHO_DIR (1023 -> 0). destino+1 wraps the same way.
//  - Simultaneous stall+salto: redirect wins, stall is dropped for this block.
//  - Reset mid-stall or mid-HALT: immediate return to reset state, no pending data kept.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined:
//    adds outputs cnt_instr[31:0] (edges with valida_out && !stall && !salto_valido)
//    and cnt_stall[31:0] (edges with stall in FETCH).
//    Both saturate at 32'hFFFFFFFF; async reset to 0; frozen in HALT.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1 rom[0]=3C0280FF, rom[1..]=0; release reset -> edge1 instr_out=3C0280FF pc_out=0 valid=1;
//    edge2 pc_out=1 instr 0 -> edge3 detenido=1, valid=0, direccion stays 1.
//  2 rom[0..3]=00210820; stall high for edges 3-4 -> pc_out holds 2, instr_out stable,
//    direccion=2; release -> pc_out 3 next edge.
//  3 salto_valido=1 destino=32 while at pc_out=2 -> direccion=32 same cycle;
//    next edge pc_out=32, valid=1.
//  4 stall=1 and salto_valido=1 destino=5 on same edge -> pc_out=5, pc=6, no hold.
//  5 destino=1023 -> pc_out=1023 then 0 then 1 (wrap).
//  6 reset_n low mid-stall/HALT -> valid=0, detenido=0, direccion=0 without clock;
//    with FETCH_PERF_CNT_EN counters=0, then count 4 instr / 2 stalls in scenario 2.

Source files
------------

// File: rtl/unidad_fetch.sv
// Instruction-fetch initiator: drives the instruction-memory address and presents
// {instruction, PC, valid} to IF/ID. Optional perf counters under FETCH_PERF_CNT_EN.
module unidad_fetch #(
  parameter int                   ANCHO_DIR = 10,
  parameter logic [ANCHO_DIR-1:0] PC_RESET  = '0,
  parameter logic [31:0]          HLT_CODE  = 32'h00000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic [ANCHO_DIR-1:0] direccion,
  input  logic [31:0]          instruccion_mem,
  input  logic                 stall,
  input  logic                 salto_valido,
  input  logic [ANCHO_DIR-1:0] salto_destino,
  output logic [31:0]          instr_out,
  output logic [ANCHO_DIR-1:0] pc_out,
  output logic                 valida_out,
  output logic                 detenido
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]          cnt_instr,
  output logic [31:0]          cnt_stall
`endif
);

  typedef enum logic [1:0] {ARRANQUE, FETCH, HALT} estado_t;

  localparam logic [ANCHO_DIR-1:0] UNO = {{(ANCHO_DIR-1){1'b0}}, 1'b1};

  estado_t              estado, estado_sig;
  logic [ANCHO_DIR-1:0] pc, pc_sig;
  logic [ANCHO_DIR-1:0] pc_pend, pc_pend_sig;
  logic                 pend_valid, pend_valid_sig;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado     <= ARRANQUE;
      pc         <= PC_RESET;
      pc_pend    <= PC_RESET;
      pend_valid <= 1'b0;
    end else begin
      estado     <= estado_sig;
      pc         <= pc_sig;
      pc_pend    <= pc_pend_sig;
      pend_valid <= pend_valid_sig;
    end
  end

  // Redirect beats stall beats normal advance; a redirect also leaves HALT.
  always_comb begin
    estado_sig     = estado;
    pc_sig         = pc;
    pc_pend_sig    = pc_pend;
    pend_valid_sig = pend_valid;
    if (salto_valido) begin
      pc_pend_sig    = salto_destino;
      pc_sig         = salto_destino + UNO;
      pend_valid_sig = 1'b1;
      estado_sig     = FETCH;
    end else begin
      unique case (estado)
        ARRANQUE: begin
          pc_pend_sig    = pc;
          pc_sig         = pc + UNO;
          pend_valid_sig = 1'b1;
          estado_sig     = FETCH;
        end
        FETCH: begin
          if (!stall) begin
            if (valida_out && (instr_out == HLT_CODE)) begin
              estado_sig = HALT;
            end else begin
              pc_pend_sig    = pc;
              pc_sig         = pc + UNO;
              pend_valid_sig = 1'b1;
            end
          end
        end
        HALT: begin
          estado_sig = HALT;
        end
        default: begin
          estado_sig = ARRANQUE;
        end
      endcase
    end
  end

  // Re-reading pc_pend keeps the memory output stable while stalled or halted.
  assign direccion  = salto_valido ? salto_destino
                    : (stall || (estado == HALT)) ? pc_pend : pc;
  assign instr_out  = instruccion_mem;
  assign pc_out     = pc_pend;
  assign valida_out = pend_valid && (estado != HALT);
  assign detenido   = (estado == HALT);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_instr <= 32'd0;
      cnt_stall <= 32'd0;
    end else if (estado != HALT) begin
      if (valida_out && !stall && !salto_valido && (cnt_instr != 32'hFFFFFFFF))
        cnt_instr <= cnt_instr + 32'd1;
      if ((estado == FETCH) && stall && (cnt_stall != 32'hFFFFFFFF))
        cnt_stall <= cnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unidad_fetch.sv
// Self-checking bench for unidad_fetch with a registered ROM model and an
// expected-output scoreboard; counter checks run when FETCH_PERF_CNT_EN is defined.
module tb_unidad_fetch;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] instr;
    logic        valid;
    logic        halt;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic [9:0]  direccion;
  logic [31:0] instruccion_mem;
  logic        stall;
  logic        salto_valido;
  logic [9:0]  salto_destino;
  logic [31:0] instr_out;
  logic [9:0]  pc_out;
  logic        valida_out;
  logic        detenido;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_instr;
  logic [31:0] cnt_stall;
`endif

  logic [31:0] rom [0:1023];
  exp_t        sb [$];
  int          check_count;
  int          error_count;

  unidad_fetch dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .direccion       (direccion),
    .instruccion_mem (instruccion_mem),
    .stall           (stall),
    .salto_valido    (salto_valido),
    .salto_destino   (salto_destino),
    .instr_out       (instr_out),
    .pc_out          (pc_out),
    .valida_out      (valida_out),
    .detenido        (detenido)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_instr       (cnt_instr),
    .cnt_stall       (cnt_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction memory with one cycle of read latency.
  always @(posedge clk) instruccion_mem <= rom[direccion];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic loadRom(input bit program_two);
    for (int i = 0; i < 1024; i++) rom[i] = program_two ? (32'hA0000000 | i) : 32'h0;
    if (program_two) begin
      for (int i = 0; i < 4; i++) rom[i] = 32'h00210820;
    end else begin
      rom[0] = 32'h3C0280FF;
    end
  endtask

  // Asserts reset away from a clock edge, checks the reset state, then releases.
  task automatic resetAndCheck(input string tag);
    reset_n = 1'b0;
    #1;
    checkOutput({tag, "_dir"}, 32'(direccion), 32'd0);
    checkOutput({tag, "_valid"}, 32'(valida_out), 32'd0);
    checkOutput({tag, "_halt"}, 32'(detenido), 32'd0);
    checkOutput({tag, "_pc"}, 32'(pc_out), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput({tag, "_cnti"}, cnt_instr, 32'd0);
    checkOutput({tag, "_cnts"}, cnt_stall, 32'd0);
`endif
    stall = 1'b0;
    salto_valido = 1'b0;
    salto_destino = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic sv, input logic [9:0] dest,
                               input logic [9:0] exp_dir, input logic [9:0] exp_pc,
                               input logic [31:0] exp_instr, input logic exp_valid, input logic exp_halt);
    exp_t e;
    stall = st;
    salto_valido = sv;
    salto_destino = dest;
    #1;
    checkOutput({tag, "_dir"}, 32'(direccion), 32'(exp_dir));
    sb.push_back('{pc: exp_pc, instr: exp_instr, valid: exp_valid, halt: exp_halt});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checkOutput({tag, "_pc"}, 32'(pc_out), 32'(e.pc));
    checkOutput({tag, "_instr"}, instr_out, e.instr);
    checkOutput({tag, "_valid"}, 32'(valida_out), 32'(e.valid));
    checkOutput({tag, "_halt"}, 32'(detenido), 32'(e.halt));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    error_count = 0;
    stall = 1'b0;
    salto_valido = 1'b0;
    salto_destino = '0;
    reset_n = 1'b0;

    // HLT detection after one real instruction, then exit from HALT via a redirect.
    loadRom(1'b0);
    #2;
    resetAndCheck("rst0");
    applyStimulus("h_e1", 0, 0, 0,  10'd0, 10'd0, 32'h3C0280FF, 1, 0);
    applyStimulus("h_e2", 0, 0, 0,  10'd1, 10'd1, 32'h0, 1, 0);
    applyStimulus("h_e3", 0, 0, 0,  10'd2, 10'd1, 32'h0, 0, 1);
    applyStimulus("h_e4", 0, 0, 0,  10'd1, 10'd1, 32'h0, 0, 1);
    applyStimulus("h_jmp", 0, 1, 10'd3, 10'd3, 10'd3, 32'h0, 1, 0);
    applyStimulus("h_e6", 0, 0, 0,  10'd4, 10'd3, 32'h0, 0, 1);
    @(negedge clk);
    resetAndCheck("rst_halt");

    // Stall holds PC and the presented word; counters see 4 instructions and 2 stalls.
    loadRom(1'b1);
    resetAndCheck("rst2");
    applyStimulus("s_e1", 0, 0, 0, 10'd0, 10'd0, 32'h00210820, 1, 0);
    applyStimulus("s_e2", 0, 0, 0, 10'd1, 10'd1, 32'h00210820, 1, 0);
    applyStimulus("s_e3", 0, 0, 0, 10'd2, 10'd2, 32'h00210820, 1, 0);
    applyStimulus("s_st1", 1, 0, 0, 10'd2, 10'd2, 32'h00210820, 1, 0);
    applyStimulus("s_st2", 1, 0, 0, 10'd2, 10'd2, 32'h00210820, 1, 0);
    applyStimulus("s_e6", 0, 0, 0, 10'd3, 10'd3, 32'h00210820, 1, 0);
    applyStimulus("s_e7", 0, 0, 0, 10'd4, 10'd4, 32'hA0000004, 1, 0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("cnt_instr", cnt_instr, 32'd4);
    checkOutput("cnt_stall", cnt_stall, 32'd2);
`endif
    stall = 1'b1;
    #3;
    resetAndCheck("rst_stall");

    // Stall ignored in ARRANQUE, then redirect, stall+redirect and address wrap.
    applyStimulus("j_e1", 1, 0, 0, 10'd0, 10'd0, 32'h00210820, 1, 0);
    applyStimulus("j_e2", 0, 0, 0, 10'd1, 10'd1, 32'h00210820, 1, 0);
    applyStimulus("j_e3", 0, 0, 0, 10'd2, 10'd2, 32'h00210820, 1, 0);
    applyStimulus("j_32", 0, 1, 10'd32, 10'd32, 10'd32, 32'hA0000020, 1, 0);
    applyStimulus("j_33", 0, 0, 0, 10'd33, 10'd33, 32'hA0000021, 1, 0);
    applyStimulus("sj_5", 1, 1, 10'd5, 10'd5, 10'd5, 32'hA0000005, 1, 0);
    applyStimulus("sj_6", 0, 0, 0, 10'd6, 10'd6, 32'hA0000006, 1, 0);
    applyStimulus("w_1023", 0, 1, 10'd1023, 10'd1023, 10'd1023, 32'hA00003FF, 1, 0);
    applyStimulus("w_0", 0, 0, 0, 10'd0, 10'd0, 32'h00210820, 1, 0);
    applyStimulus("w_1", 0, 0, 0, 10'd1, 10'd1, 32'h00210820, 1, 0);

    if (sb.size() != 0) begin
      error_count++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
